// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS controller:
// state enum, opcode/funct values, ALU control codes and mux encodings.
package mips_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned ALUCTL_W = 3;
    localparam int unsigned ALUOP_W  = 2;
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned SRCB_W   = 2;
    localparam int unsigned PCSRC_W  = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_FETCH_PC = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_EXECUTE  = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_ADDIEX   = 4'd10,
        S_ADDIWB   = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b111;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SRCB_W-1:0] SRCB_REGB     = 2'b00;
    localparam logic [SRCB_W-1:0] SRCB_FOUR     = 2'b01;
    localparam logic [SRCB_W-1:0] SRCB_SEXT     = 2'b10;
    localparam logic [SRCB_W-1:0] SRCB_SEXT_SH2 = 2'b11;

    localparam logic [PCSRC_W-1:0] PCSRC_NONE = 2'b00;
    localparam logic [PCSRC_W-1:0] PCSRC_ALU  = 2'b01;
    localparam logic [PCSRC_W-1:0] PCSRC_JUMP = 2'b10;

    // Opcodes that DECODE can dispatch; anything else is illegal.
    function automatic logic opcode_known(input logic [OPCODE_W-1:0] op);
        logic known;
        known = 1'b0;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: known = 1'b1;
            default:                                       known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and zero flag in, mux selects and strobes out.
interface mips_ctrl_if;
    import mips_pkg::*;

    logic [OPCODE_W-1:0] opcode_i;
    logic [FUNCT_W-1:0]  funct_i;
    logic                zero_i;
    logic [ALUCTL_W-1:0] aluControl_o;
    logic                aluSrcA_o;
    logic [SRCB_W-1:0]   aluSrcB_o;
    logic                iorD_o;
    logic                memWrite_o;
    logic                irWrite_o;
    logic                regDst_o;
    logic                memToReg_o;
    logic                regWrite_o;
    logic [PCSRC_W-1:0]  pcSrc_o;
    logic                pcEn_o;
    logic                illegal_o;
    logic [STATE_W-1:0]  state_o;

    modport master (
        input  opcode_i, funct_i, zero_i,
        output aluControl_o, aluSrcA_o, aluSrcB_o, iorD_o, memWrite_o, irWrite_o,
               regDst_o, memToReg_o, regWrite_o, pcSrc_o, pcEn_o, illegal_o, state_o
    );

    modport slave (
        output opcode_i, funct_i, zero_i,
        input  aluControl_o, aluSrcA_o, aluSrcB_o, iorD_o, memWrite_o, irWrite_o,
               regDst_o, memToReg_o, regWrite_o, pcSrc_o, pcEn_o, illegal_o, state_o
    );

endinterface

// File: rtl/mips_multicycle_ctrl_alu_dec.sv
// ALU decoder: maps (aluOp, funct) to the 3-bit ALU control and flags unsupported functs.
module mips_alu_dec
    import mips_pkg::*;
(
    input  logic [ALUOP_W-1:0]  i_alu_op,
    input  logic [FUNCT_W-1:0]  i_funct,
    output logic [ALUCTL_W-1:0] o_alu_control_c,
    output logic                o_funct_illegal_c
);

    logic [ALUCTL_W-1:0] w_funct_ctl;

    // Funct validity is independent of aluOp so DECODE can flag it early.
    always_comb begin
        w_funct_ctl       = ALU_ADD;
        o_funct_illegal_c = 1'b0;
        case (i_funct)
            FN_ADD:  w_funct_ctl = ALU_ADD;
            FN_SUB:  w_funct_ctl = ALU_SUB;
            FN_AND:  w_funct_ctl = ALU_AND;
            FN_OR:   w_funct_ctl = ALU_OR;
            FN_SLT:  w_funct_ctl = ALU_SLT;
            default: o_funct_illegal_c = 1'b1;
        endcase
    end

    always_comb begin
        o_alu_control_c = ALU_ADD;
        case (i_alu_op)
            ALUOP_ADD:   o_alu_control_c = ALU_ADD;
            ALUOP_SUB:   o_alu_control_c = ALU_SUB;
            ALUOP_FUNCT: o_alu_control_c = w_funct_ctl;
            default:     o_alu_control_c = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register, memory-latency counter and Moore output decode.
// Strobes are gated by reset so nothing fires while rst_i is high.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    mips_ctrl_if.master bus
);

    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_mem_cnt;
    logic [CNT_W-1:0]    w_mem_cnt_nxt;
    logic                w_mem_last;
    logic [CNT_W-1:0]    w_mem_cnt_inc;

    logic [ALUOP_W-1:0]  w_alu_op;
    logic [ALUCTL_W-1:0] w_alu_control;
    logic                w_funct_illegal;
    logic                w_decode_illegal;
    logic                w_src_a;
    logic [SRCB_W-1:0]   w_src_b;
    logic                w_iord;
    logic                w_reg_dst;
    logic                w_mem_to_reg;
    logic [PCSRC_W-1:0]  w_pc_src;
    logic                w_mem_write;
    logic                w_ir_write;
    logic                w_reg_write;
    logic                w_pc_write;
    logic                w_branch;
    logic                w_illegal;

    assign w_mem_last       = (r_mem_cnt == CNT_LAST);
    assign w_mem_cnt_inc    = r_mem_cnt + CNT_W'(1);
    assign w_decode_illegal = !opcode_known(bus.opcode_i) ||
                              ((bus.opcode_i == OP_RTYPE) && w_funct_illegal);

    mips_alu_dec u_alu_dec (
        .i_alu_op          (w_alu_op),
        .i_funct           (bus.funct_i),
        .o_alu_control_c   (w_alu_control),
        .o_funct_illegal_c (w_funct_illegal)
    );

    // Next state; the counter only runs in FETCH/MEMRD/MEMWR and clears on exit.
    always_comb begin
        w_state_nxt   = r_state;
        w_mem_cnt_nxt = '0;
        case (r_state)
            S_FETCH: begin
                if (w_mem_last) w_state_nxt   = S_FETCH_PC;
                else            w_mem_cnt_nxt = w_mem_cnt_inc;
            end
            S_FETCH_PC: w_state_nxt = S_DECODE;
            S_DECODE: begin
                case (bus.opcode_i)
                    OP_LW, OP_SW: w_state_nxt = S_MEMADR;
                    OP_RTYPE:     w_state_nxt = w_funct_illegal ? S_FETCH : S_EXECUTE;
                    OP_BEQ:       w_state_nxt = S_BRANCH;
                    OP_ADDI:      w_state_nxt = S_ADDIEX;
                    OP_J:         w_state_nxt = S_JUMP;
                    default:      w_state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: w_state_nxt = (bus.opcode_i == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (w_mem_last) w_state_nxt   = S_MEMWB;
                else            w_mem_cnt_nxt = w_mem_cnt_inc;
            end
            S_MEMWR: begin
                if (w_mem_last) w_state_nxt   = S_FETCH;
                else            w_mem_cnt_nxt = w_mem_cnt_inc;
            end
            S_EXECUTE: w_state_nxt = S_ALUWB;
            S_ADDIEX:  w_state_nxt = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: w_state_nxt = S_FETCH;
            default:   w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_FETCH;
            r_mem_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_mem_cnt <= w_mem_cnt_nxt;
        end
    end

    // Moore decode; writeback and memory states hold the ALU setup of the state before them.
    always_comb begin
        w_alu_op     = ALUOP_ADD;
        w_src_a      = 1'b0;
        w_src_b      = SRCB_FOUR;
        w_iord       = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_pc_src     = PCSRC_NONE;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH: w_ir_write = w_mem_last;
            S_FETCH_PC: begin
                w_pc_src   = PCSRC_ALU;
                w_pc_write = 1'b1;
            end
            S_DECODE: begin
                w_src_b   = SRCB_SEXT_SH2;
                w_illegal = w_decode_illegal;
            end
            S_MEMADR, S_ADDIEX: begin
                w_src_a = 1'b1;
                w_src_b = SRCB_SEXT;
            end
            S_MEMRD: begin
                w_src_a = 1'b1;
                w_src_b = SRCB_SEXT;
                w_iord  = 1'b1;
            end
            S_MEMWB: begin
                w_src_a      = 1'b1;
                w_src_b      = SRCB_SEXT;
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
            end
            S_MEMWR: begin
                w_src_a     = 1'b1;
                w_src_b     = SRCB_SEXT;
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECUTE: begin
                w_src_a  = 1'b1;
                w_src_b  = SRCB_REGB;
                w_alu_op = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                w_src_a     = 1'b1;
                w_src_b     = SRCB_REGB;
                w_alu_op    = ALUOP_FUNCT;
                w_reg_dst   = 1'b1;
                w_reg_write = 1'b1;
            end
            S_BRANCH: begin
                w_src_a  = 1'b1;
                w_src_b  = SRCB_REGB;
                w_alu_op = ALUOP_SUB;
                w_pc_src = PCSRC_ALU;
                w_branch = 1'b1;
            end
            S_ADDIWB: begin
                w_src_a     = 1'b1;
                w_src_b     = SRCB_SEXT;
                w_reg_write = 1'b1;
            end
            S_JUMP: begin
                w_pc_src   = PCSRC_JUMP;
                w_pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.aluControl_o = w_alu_control;
    assign bus.aluSrcA_o    = w_src_a;
    assign bus.aluSrcB_o    = w_src_b;
    assign bus.iorD_o       = w_iord;
    assign bus.regDst_o     = w_reg_dst;
    assign bus.memToReg_o   = w_mem_to_reg;
    assign bus.pcSrc_o      = w_pc_src;
    assign bus.state_o      = r_state;

    assign bus.memWrite_o   = w_mem_write & ~rst_i;
    assign bus.irWrite_o    = w_ir_write  & ~rst_i;
    assign bus.regWrite_o   = w_reg_write & ~rst_i;
    assign bus.illegal_o    = w_illegal   & ~rst_i;
    assign bus.pcEn_o       = (w_pc_write | (w_branch & bus.zero_i)) & ~rst_i;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: three instances (MEM_LAT 1..3), directed and random
// instruction streams checked cycle by cycle against a per-instruction expected-cycle list.
module tb_mips_multicycle_ctrl;
    import mips_pkg::*;

    localparam int unsigned NI = 3;

    typedef struct packed {
        logic [3:0] st;
        logic [2:0] alu;
        logic       srcA;
        logic [1:0] srcB;
        logic       iorD;
        logic       regDst;
        logic       memToReg;
        logic [1:0] pcSrc;
        logic       memWrite;
        logic       irWrite;
        logic       regWrite;
        logic       pcEn;
        logic       illegal;
    } sig_t;

    // care bits: [0]alu [1]srcA [2]srcB [3]iorD [4]regDst [5]memToReg [6]pcSrc
    typedef struct packed {
        sig_t       v;
        logic [6:0] care;
    } exp_t;

    localparam logic [6:0] C_ALU  = 7'b0000111;
    localparam logic [6:0] C_IORD = 7'b0001000;
    localparam logic [6:0] C_WB   = 7'b0110000;
    localparam logic [6:0] C_PC   = 7'b1000000;

    logic       clk;
    logic       rst_v [NI];
    logic [5:0] opc   [NI];
    logic [5:0] fnc   [NI];
    logic       zr    [NI];
    sig_t       obs   [NI];

    int   n_checks;
    int   n_pass;
    int   n_fail;
    exp_t q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mips_ctrl_if u_if ();
        assign u_if.opcode_i = opc[g];
        assign u_if.funct_i  = fnc[g];
        assign u_if.zero_i   = zr[g];
        mips_multicycle_ctrl #(.MEM_LAT(g + 1)) u_dut (
            .clk_i (clk),
            .rst_i (rst_v[g]),
            .bus   (u_if.master)
        );
        assign obs[g] = {u_if.state_o, u_if.aluControl_o, u_if.aluSrcA_o, u_if.aluSrcB_o,
                         u_if.iorD_o, u_if.regDst_o, u_if.memToReg_o, u_if.pcSrc_o,
                         u_if.memWrite_o, u_if.irWrite_o, u_if.regWrite_o, u_if.pcEn_o,
                         u_if.illegal_o};
    end

    // {legal, aluControl} for an R-type funct
    function automatic logic [3:0] ref_funct(input logic [5:0] f);
        case (f)
            6'b100000: return 4'b1010;
            6'b100010: return 4'b1110;
            6'b100100: return 4'b1000;
            6'b100101: return 4'b1001;
            6'b101010: return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

    function automatic logic ref_op_known(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    function automatic exp_t mk(input state_t s, input logic [2:0] a, input logic sa,
                                input logic [1:0] sb, input logic [6:0] care);
        exp_t e;
        e        = '0;
        e.v.st   = s;
        e.v.alu  = a;
        e.v.srcA = sa;
        e.v.srcB = sb;
        e.care   = care;
        return e;
    endfunction

    // Expected per-cycle outputs of one instruction, from FETCH to its last cycle.
    task automatic build(input int L, input logic [5:0] op, input logic [5:0] f, input logic z);
        exp_t       e;
        logic [3:0] rf;
        logic       bad;
        q.delete();
        rf  = ref_funct(f);
        bad = !ref_op_known(op) || ((op == 6'b000000) && !rf[3]);
        for (int i = 0; i < L; i++) begin
            e = mk(S_FETCH, 3'b010, 1'b0, 2'b01, C_ALU | C_IORD);
            e.v.irWrite = (i == L - 1);
            q.push_back(e);
        end
        e = mk(S_FETCH_PC, 3'b000, 1'b0, 2'b00, C_PC);
        e.v.pcSrc = 2'b01;
        e.v.pcEn  = 1'b1;
        q.push_back(e);
        e = mk(S_DECODE, 3'b010, 1'b0, 2'b11, C_ALU);
        e.v.illegal = bad;
        q.push_back(e);
        if (!bad) begin
            case (op)
                6'b100011, 6'b101011: begin
                    q.push_back(mk(S_MEMADR, 3'b010, 1'b1, 2'b10, C_ALU));
                    for (int i = 0; i < L; i++) begin
                        e = mk((op == 6'b101011) ? S_MEMWR : S_MEMRD, 3'b010, 1'b1, 2'b10,
                               C_ALU | C_IORD);
                        e.v.iorD     = 1'b1;
                        e.v.memWrite = (op == 6'b101011);
                        q.push_back(e);
                    end
                    if (op == 6'b100011) begin
                        e = mk(S_MEMWB, 3'b000, 1'b0, 2'b00, C_WB);
                        e.v.memToReg = 1'b1;
                        e.v.regWrite = 1'b1;
                        q.push_back(e);
                    end
                end
                6'b000000: begin
                    q.push_back(mk(S_EXECUTE, rf[2:0], 1'b1, 2'b00, C_ALU));
                    e = mk(S_ALUWB, rf[2:0], 1'b1, 2'b00, C_ALU | C_WB);
                    e.v.regDst   = 1'b1;
                    e.v.regWrite = 1'b1;
                    q.push_back(e);
                end
                6'b000100: begin
                    e = mk(S_BRANCH, 3'b110, 1'b1, 2'b00, C_ALU | C_PC);
                    e.v.pcSrc = 2'b01;
                    e.v.pcEn  = z;
                    q.push_back(e);
                end
                6'b001000: begin
                    q.push_back(mk(S_ADDIEX, 3'b010, 1'b1, 2'b10, C_ALU));
                    e = mk(S_ADDIWB, 3'b010, 1'b1, 2'b10, C_ALU | C_WB);
                    e.v.regWrite = 1'b1;
                    q.push_back(e);
                end
                6'b000010: begin
                    e = mk(S_JUMP, 3'b000, 1'b0, 2'b00, C_PC);
                    e.v.pcSrc = 2'b10;
                    e.v.pcEn  = 1'b1;
                    q.push_back(e);
                end
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] o, input logic [3:0] x);
        n_checks++;
        assert (o === x) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, x);
        end
    endtask

    task automatic check_cycle(input int k, input exp_t e, input string tag);
        sig_t o;
        o = obs[k];
        chk({tag, " state"},    o.st,               e.v.st);
        chk({tag, " memWrite"}, 4'(o.memWrite),     4'(e.v.memWrite));
        chk({tag, " irWrite"},  4'(o.irWrite),      4'(e.v.irWrite));
        chk({tag, " regWrite"}, 4'(o.regWrite),     4'(e.v.regWrite));
        chk({tag, " pcEn"},     4'(o.pcEn),         4'(e.v.pcEn));
        chk({tag, " illegal"},  4'(o.illegal),      4'(e.v.illegal));
        if (e.care[0]) chk({tag, " aluControl"}, 4'(o.alu),      4'(e.v.alu));
        if (e.care[1]) chk({tag, " aluSrcA"},    4'(o.srcA),     4'(e.v.srcA));
        if (e.care[2]) chk({tag, " aluSrcB"},    4'(o.srcB),     4'(e.v.srcB));
        if (e.care[3]) chk({tag, " iorD"},       4'(o.iorD),     4'(e.v.iorD));
        if (e.care[4]) chk({tag, " regDst"},     4'(o.regDst),   4'(e.v.regDst));
        if (e.care[5]) chk({tag, " memToReg"},   4'(o.memToReg), 4'(e.v.memToReg));
        if (e.care[6]) chk({tag, " pcSrc"},      4'(o.pcSrc),    4'(e.v.pcSrc));
    endtask

    // While reset is high: FETCH, FETCH selects, every strobe low.
    task automatic check_reset(input int k, input string tag);
        exp_t e;
        e = mk(S_FETCH, 3'b010, 1'b0, 2'b01, C_ALU | C_IORD);
        check_cycle(k, e, tag);
    endtask

    task automatic reset_phase(input int k);
        rst_v[k] = 1'b1;
        zr[k]    = 1'b1;
        opc[k]   = 6'($urandom());
        fnc[k]   = 6'($urandom());
        repeat (3) begin
            @(negedge clk);
            #1;
            check_reset(k, $sformatf("L%0d reset", k + 1));
        end
        @(negedge clk);
        rst_v[k] = 1'b0;
    endtask

    // Entered on a negedge; returns on the negedge that starts the next instruction.
    task automatic run_instr(input int k, input logic [5:0] op, input logic [5:0] f,
                             input logic z, input int abort_at);
        build(k + 1, op, f, z);
        opc[k] = op;
        fnc[k] = f;
        zr[k]  = z;
        foreach (q[i]) begin
            #1;
            check_cycle(k, q[i], $sformatf("L%0d op%b fn%b c%0d", k + 1, op, f, i));
            if (i == abort_at) begin
                rst_v[k] = 1'b1;
                #1;
                check_reset(k, $sformatf("L%0d abort c%0d", k + 1, i));
                repeat (2) begin
                    @(negedge clk);
                    #1;
                    check_reset(k, $sformatf("L%0d abort hold", k + 1));
                end
                @(negedge clk);
                rst_v[k] = 1'b0;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic rand_instrs(input int k, input int n);
        logic [5:0] fl [5];
        logic [5:0] op;
        logic [5:0] f;
        logic       z;
        fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        for (int i = 0; i < n; i++) begin
            f = 6'($urandom());
            z = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: op = 6'b100011;
                1: op = 6'b101011;
                2: begin op = 6'b000000; f = fl[$urandom_range(0, 4)]; end
                3: op = 6'b000100;
                4: op = 6'b001000;
                5: op = 6'b000010;
                6: op = 6'b000000;
                default: op = 6'($urandom());
            endcase
            run_instr(k, op, f, z, -1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        for (int k = 0; k < NI; k++) begin
            rst_v[k] = 1'b1;
            opc[k]   = 6'b000000;
            fnc[k]   = 6'b000000;
            zr[k]    = 1'b0;
        end
        repeat (2) @(negedge clk);

        // MEM_LAT = 1
        reset_phase(0);
        run_instr(0, 6'b100011, 6'b010101, 1'b1, -1);
        run_instr(0, 6'b000000, 6'b101010, 1'b1, -1);
        run_instr(0, 6'b000000, 6'b100010, 1'b0, -1);
        run_instr(0, 6'b000100, 6'b000000, 1'b1, -1);
        run_instr(0, 6'b000100, 6'b000000, 1'b0, -1);
        run_instr(0, 6'b001000, 6'b111000, 1'b1, -1);
        run_instr(0, 6'b000010, 6'b000000, 1'b0, -1);
        run_instr(0, 6'b111111, 6'b100000, 1'b0, -1);
        run_instr(0, 6'b000000, 6'b000001, 1'b1, -1);
        run_instr(0, 6'b000100, 6'b000000, 1'b1, 3);
        run_instr(0, 6'b100011, 6'b000000, 1'b0, -1);
        rand_instrs(0, 40);
        rst_v[0] = 1'b1;

        // MEM_LAT = 2
        reset_phase(1);
        run_instr(1, 6'b101011, 6'b000000, 1'b0, -1);
        run_instr(1, 6'b000010, 6'b000000, 1'b1, -1);
        run_instr(1, 6'b111111, 6'b000000, 1'b1, -1);
        run_instr(1, 6'b101011, 6'b000000, 1'b1, 5);
        run_instr(1, 6'b101011, 6'b000000, 1'b0, -1);
        rand_instrs(1, 40);
        rst_v[1] = 1'b1;

        // MEM_LAT = 3
        reset_phase(2);
        run_instr(2, 6'b100011, 6'b000000, 1'b0, -1);
        run_instr(2, 6'b101011, 6'b000000, 1'b1, -1);
        run_instr(2, 6'b000000, 6'b100100, 1'b0, -1);
        rand_instrs(2, 40);
        rst_v[2] = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
